// File: rtl/xsm_fifo_fwft.sv
// Synchronous FWFT FIFO: BRAM with registered read, prefetch into an output register, programmable flags.
// Optional peak-occupancy watermark (max_level, wm_clear) is enabled by defining XSM_FIFO_WATERMARK_EN.
module xsm_fifo_fwft #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef XSM_FIFO_WATERMARK_EN
    output logic [CNT_W-1:0]      max_level,
    input  logic                  wm_clear,
`endif
    output logic [CNT_W-1:0]      fill_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // state[1] = output register holds the head, state[0] = BRAM read in flight
    typedef enum logic [1:0] {
        EMPTY       = 2'b00,
        FETCH       = 2'b01,
        VALID       = 2'b10,
        VALID_FETCH = 2'b11
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W:0]          wptr_q, wptr_d;
    logic [PTR_W:0]          rptr_q, rptr_d;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    af_q, ae_q;
    logic                    init_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    push, pop;
    logic                    head_vld, fetch_vld;
    logic                    load_out, rd_en, mem_nonempty;

    assign in_ready     = (fill_q < DEPTH_C);
    assign head_vld     = state_q[1];
    assign fetch_vld    = state_q[0];
    assign out_valid    = head_vld;
    assign out_data     = out_data_q;
    assign fill_level   = fill_q;
    assign almost_empty = ae_q;
    // Before the first edge out of reset the flag reflects an empty FIFO against the live threshold.
    assign almost_full  = init_q ? (af_thresh == '0) : af_q;

    assign push         = in_valid && in_ready;
    assign pop          = head_vld && out_ready;
    assign mem_nonempty = (wptr_q != rptr_q);
    // The in-flight word moves to the head when the head is free or leaving; the BRAM output
    // register keeps a stalled word, so a new read is only issued once that slot drains.
    assign load_out     = fetch_vld && (!head_vld || pop);
    assign rd_en        = mem_nonempty && (!fetch_vld || load_out);

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fill_d     = fill_q;
        out_data_d = out_data_q;
        if (flush) begin
            state_d    = EMPTY;
            wptr_d     = '0;
            rptr_d     = '0;
            fill_d     = '0;
            out_data_d = '0;
        end else begin
            state_d    = state_e'({load_out || (head_vld && !pop), rd_en || (fetch_vld && !load_out)});
            wptr_d     = wptr_q + {{PTR_W{1'b0}}, push};
            rptr_d     = rptr_q + {{PTR_W{1'b0}}, rd_en};
            fill_d     = fill_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
            if (load_out) begin
                out_data_d = rdata_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fill_q     <= '0;
            out_data_q <= '0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            init_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fill_q     <= fill_d;
            out_data_q <= out_data_d;
            af_q       <= (fill_d >= af_thresh);
            ae_q       <= (fill_d <= ae_thresh);
            init_q     <= 1'b0;
        end
    end

    // Storage is left unreset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wptr_q[PTR_W-1:0]] <= in_data;
        end
        if (rd_en) begin
            rdata_q <= mem_q[rptr_q[PTR_W-1:0]];
        end
    end

`ifdef XSM_FIFO_WATERMARK_EN
    logic [CNT_W-1:0] max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else if (flush) begin
            max_q <= '0;
        end else if (wm_clear) begin
            max_q <= fill_q;
        end else if (fill_d > max_q) begin
            max_q <= fill_d;
        end
    end

    assign max_level = max_q;
`endif

endmodule

// File: tb/tb_xsm_fifo_fwft.sv
// Randomised bench for xsm_fifo_fwft against a queue model that tracks each entry's push time.
module tb_xsm_fifo_fwft;
    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] fill_level;
`ifdef XSM_FIFO_WATERMARK_EN
    logic [CW-1:0] max_level;
    logic          wm_clear;
`endif

    xsm_fifo_fwft #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef XSM_FIFO_WATERMARK_EN
        .max_level    (max_level),
        .wm_clear     (wm_clear),
`endif
        .fill_level   (fill_level)
    );

    always #5 clk = ~clk;

    // Model: each entry remembers the edge that accepted it; it is visible at the head two edges later.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t q[$];
    int   cyc;
    int   m_max;
    int   n_chk;
    int   n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit exp_ov();
        return (q.size() > 0) && (q[0].t + 2 <= cyc);
    endfunction

    task automatic check_all();
        chk("fill_level", 32'(fill_level), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(exp_ov()));
        if (exp_ov()) chk("out_data", 32'(out_data), 32'(q[0].d));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= int'(af_thresh)));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= int'(ae_thresh)));
`ifdef XSM_FIFO_WATERMARK_EN
        chk("max_level", 32'(max_level), 32'(m_max));
`endif
    endtask

    // Advance one clock: update the model from the pre-edge view, then compare on the falling edge.
    task automatic step();
        bit   m_push, m_pop, m_clr;
        int   pre_size;
        ent_t e;
        pre_size = q.size();
        m_push = in_valid && (pre_size < DEPTH);
        m_pop  = exp_ov() && out_ready;
        m_clr  = 1'b0;
`ifdef XSM_FIFO_WATERMARK_EN
        m_clr  = wm_clear;
`endif
        e.d = in_data;
        @(posedge clk);
        cyc++;
        e.t = cyc;
        if (flush) begin
            q.delete();
            m_max = 0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(e);
            if (m_clr) m_max = pre_size;
            else if (q.size() > m_max) m_max = q.size();
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; m_max = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        af_thresh = 4'd6; ae_thresh = 4'd1;
`ifdef XSM_FIFO_WATERMARK_EN
        wm_clear = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // Single entry: two-edge latency, hold while not taken, then pop.
        in_valid = 1'b1; in_data = 16'h00A5;
        step();
        in_valid = 1'b0;
        chk("lat_e0", 32'(out_valid), 32'd0);
        step();
        chk("lat_e1", 32'(out_valid), 32'd0);
        step();
        chk("lat_e2", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h00A5);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_data", 32'(out_data), 32'h00A5);
            chk("hold_fill", 32'(fill_level), 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_valid", 32'(out_valid), 32'd0);
        chk("pop_fill", 32'(fill_level), 32'd0);

        // Fill to capacity, then one refused push.
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            step();
        end
        in_valid = 1'b0;
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_fill", 32'(fill_level), 32'd8);
        chk("full_af", 32'(almost_full), 32'd1);
        step();
        chk("full_head", 32'(out_data), 32'd1);

        // Streaming at full rate through several pointer wraps.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 16'(16'h0100 + i);
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_fill", 32'(fill_level >= 4'd7 && fill_level <= 4'd8), 32'd1);
        end

        // Drain, push five, flush alongside push and pop.
        in_valid = 1'b0;
        repeat (12) step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0200 + i);
            step();
        end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h0BAD;
        step();
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_fill", 32'(fill_level), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", 32'(out_data), 32'd0);
        in_data = 16'h0C3C;
        step();
        in_valid = 1'b0;
        step();
        chk("post_flush_e1", 32'(out_valid), 32'd0);
        step();
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        chk("post_flush_data", 32'(out_data), 32'h0C3C);

        // Random traffic with occasional threshold changes and flushes.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            flush     = ($urandom_range(0, 499) == 0);
`ifdef XSM_FIFO_WATERMARK_EN
            wm_clear  = ($urandom_range(0, 199) == 0);
`endif
            if ($urandom_range(0, 63) == 0) begin
                af_thresh = 4'($urandom_range(0, DEPTH));
                ae_thresh = 4'($urandom_range(0, DEPTH));
            end
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
